// File: rtl/present_pkg.sv
// Shared types for the present-effects block: present encodings, timed-effect states, timer width.
// Pure declarations, no logic, so nothing here adds latency or flow control.
package present_pkg;

    typedef enum logic [1:0] {
        P_LIFE   = 2'd0,
        P_FREEZE = 2'd1,
        P_SHIELD = 2'd2,
        P_POINTS = 2'd3
    } present_t;

    typedef enum logic [1:0] {
        EF_IDLE   = 2'd0,
        EF_ACTIVE = 2'd1,
        EF_ENDING = 2'd2
    } effect_st_t;

    localparam int TW = 4;

endpackage

// File: rtl/present_effects_controller_effect_timer.sv
// One timed effect (IDLE/ACTIVE/ENDING) counting down on the seconds strobe; updates on the edge sampling load/tick.
// No backpressure; clear beats load, and load beats tick. Warn flop exists only with PRESENT_EFFECTS_WARN_EN.
module effect_timer
    import present_pkg::*;
#(
    parameter int DURATION  = 10,
    parameter int WARN_TIME = 3
) (
    input  logic          clk,
    input  logic          resetN,
    input  logic          clear,
    input  logic          load,
    input  logic          tick,
`ifdef PRESENT_EFFECTS_WARN_EN
    output logic          warn,
`endif
    output logic [TW-1:0] time_left
);

    localparam logic [TW-1:0] DUR_T  = TW'(DURATION);
    localparam logic [TW-1:0] WARN_T = TW'(WARN_TIME);

    effect_st_t    st, st_nxt;
    logic [TW-1:0] tmr, tmr_nxt;
    logic [TW-1:0] dec;

    assign dec = tmr - 1'b1;

    always_comb begin
        st_nxt  = st;
        tmr_nxt = tmr;
        if (clear) begin
            st_nxt  = EF_IDLE;
            tmr_nxt = '0;
        end else if (load) begin
            st_nxt  = EF_ACTIVE;
            tmr_nxt = DUR_T;
        end else if (tick && (st != EF_IDLE) && (tmr != '0)) begin
            tmr_nxt = dec;
            // Timer reaching zero always ends the effect, even if WARN_TIME is 0.
            if (dec == '0)
                st_nxt = EF_IDLE;
            else if (dec <= WARN_T)
                st_nxt = EF_ENDING;
        end
    end

    always_ff @(posedge clk) begin
        if (!resetN) begin
            st  <= EF_IDLE;
            tmr <= '0;
        end else begin
            st  <= st_nxt;
            tmr <= tmr_nxt;
        end
    end

`ifdef PRESENT_EFFECTS_WARN_EN
    always_ff @(posedge clk) begin
        if (!resetN)
            warn <= 1'b0;
        else if (st_nxt != EF_ENDING)
            warn <= 1'b0;
        else if (st != EF_ENDING)
            warn <= 1'b1;
        else if (tick)
            warn <= ~warn;
    end
`endif

    assign time_left = tmr;

endmodule

// File: rtl/present_effects_controller.sv
// Applies collected presents: one-cycle life/points pulses and freeze/shield timers, one edge after the strobe.
// No backpressure; effectsEnable=0 clears everything. Optional warn outputs: PRESENT_EFFECTS_WARN_EN.
module present_effects_controller
    import present_pkg::*;
#(
    parameter int FREEZE_TIME = 10,
    parameter int SHIELD_TIME = 10,
    parameter int WARN_TIME   = 3
) (
    input  logic          clk,
    input  logic          resetN,
    input  logic          col_present,
    input  logic [1:0]    present_type,
    input  logic          secClk,
    input  logic          effectsEnable,
    output logic          freezeActive,
    output logic          shieldActive,
    output logic [TW-1:0] freezeTimeLeft,
    output logic          lifeUp,
`ifdef PRESENT_EFFECTS_WARN_EN
    output logic          freezeWarn,
    output logic          shieldWarn,
`endif
    output logic          scoreBonus
);

    present_t      ptype;
    logic          collect;
    logic [TW-1:0] shield_left;

    assign ptype   = present_t'(present_type);
    assign collect = effectsEnable && col_present;

    always_ff @(posedge clk) begin
        if (!resetN) begin
            lifeUp     <= 1'b0;
            scoreBonus <= 1'b0;
        end else begin
            lifeUp     <= collect && (ptype == P_LIFE);
            scoreBonus <= collect && (ptype == P_POINTS);
        end
    end

    effect_timer #(
        .DURATION  (FREEZE_TIME),
        .WARN_TIME (WARN_TIME)
    ) u_freeze (
        .clk       (clk),
        .resetN    (resetN),
        .clear     (!effectsEnable),
        .load      (collect && (ptype == P_FREEZE)),
        .tick      (secClk),
`ifdef PRESENT_EFFECTS_WARN_EN
        .warn      (freezeWarn),
`endif
        .time_left (freezeTimeLeft)
    );

    effect_timer #(
        .DURATION  (SHIELD_TIME),
        .WARN_TIME (WARN_TIME)
    ) u_shield (
        .clk       (clk),
        .resetN    (resetN),
        .clear     (!effectsEnable),
        .load      (collect && (ptype == P_SHIELD)),
        .tick      (secClk),
`ifdef PRESENT_EFFECTS_WARN_EN
        .warn      (shieldWarn),
`endif
        .time_left (shield_left)
    );

    // A timer is nonzero exactly when its effect is out of IDLE.
    assign freezeActive = (freezeTimeLeft != '0);
    assign shieldActive = (shield_left != '0);

endmodule

// File: tb/tb_present_effects_controller.sv
// Directed bench for present_effects_controller with hand-computed expectations.
// Warn-flag checks are compiled only when PRESENT_EFFECTS_WARN_EN is defined.
module tb_present_effects_controller;

    logic       clk = 1'b0;
    logic       resetN;
    logic       col_present;
    logic [1:0] present_type;
    logic       secClk;
    logic       effectsEnable;
    logic       freezeActive;
    logic       shieldActive;
    logic [3:0] freezeTimeLeft;
    logic       lifeUp;
    logic       scoreBonus;
`ifdef PRESENT_EFFECTS_WARN_EN
    logic       freezeWarn;
    logic       shieldWarn;
`endif

    int tests_run    = 0;
    int tests_failed = 0;

    always #5 clk = ~clk;

    present_effects_controller dut (
        .clk            (clk),
        .resetN         (resetN),
        .col_present    (col_present),
        .present_type   (present_type),
        .secClk         (secClk),
        .effectsEnable  (effectsEnable),
        .freezeActive   (freezeActive),
        .shieldActive   (shieldActive),
        .freezeTimeLeft (freezeTimeLeft),
        .lifeUp         (lifeUp),
`ifdef PRESENT_EFFECTS_WARN_EN
        .freezeWarn     (freezeWarn),
        .shieldWarn     (shieldWarn),
`endif
        .scoreBonus     (scoreBonus)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // One clock: inputs sampled at the edge, outputs read 1ns later, strobes dropped.
    task automatic step();
        @(posedge clk);
        #1;
        col_present = 1'b0;
        secClk      = 1'b0;
    endtask

    task automatic collect(input logic [1:0] t);
        col_present  = 1'b1;
        present_type = t;
        step();
    endtask

    task automatic sec();
        secClk = 1'b1;
        step();
    endtask

    initial begin
        resetN        = 1'b0;
        col_present   = 1'b0;
        present_type  = 2'd0;
        secClk        = 1'b0;
        effectsEnable = 1'b0;
        repeat (2) step();
        chk("rst_frz_act",  freezeActive,   0);
        chk("rst_shd_act",  shieldActive,   0);
        chk("rst_frz_left", freezeTimeLeft, 0);
        chk("rst_life",     lifeUp,         0);
        chk("rst_bonus",    scoreBonus,     0);
        resetN        = 1'b1;
        effectsEnable = 1'b1;
        step();

        // Instant effects
        collect(2'd0);
        chk("life_pulse",  lifeUp,     1);
        chk("life_nobon",  scoreBonus, 0);
        collect(2'd3);
        chk("life_end",    lifeUp,     0);
        chk("bonus_pulse", scoreBonus, 1);
        step();
        chk("bonus_end",   scoreBonus, 0);

        // Full freeze countdown
        collect(2'd1);
        chk("frz_load_left", freezeTimeLeft, 10);
        chk("frz_load_act",  freezeActive,   1);
        for (int i = 1; i <= 10; i++) begin
            sec();
            chk("frz_cnt_left", freezeTimeLeft, 32'(10 - i));
            chk("frz_cnt_act",  freezeActive,   (i < 10) ? 1 : 0);
        end
        sec();
        chk("frz_nowrap", freezeTimeLeft, 0);

        // Reload in ENDING beats a simultaneous secClk
        collect(2'd1);
        for (int i = 1; i <= 8; i++) begin
            sec();
`ifdef PRESENT_EFFECTS_WARN_EN
            if (i == 7) chk("frz_warn_enter", freezeWarn, 1);
            if (i == 8) chk("frz_warn_tog",   freezeWarn, 0);
`endif
        end
        chk("frz_at2", freezeTimeLeft, 2);
        col_present  = 1'b1;
        present_type = 2'd1;
        secClk       = 1'b1;
        step();
        chk("frz_reload_left", freezeTimeLeft, 10);
        chk("frz_reload_act",  freezeActive,   1);
`ifdef PRESENT_EFFECTS_WARN_EN
        chk("frz_reload_warn", freezeWarn, 0);
`endif
        sec();
        chk("frz_after_reload", freezeTimeLeft, 9);

        // Reset mid-freeze drops it on the next edge
        resetN = 1'b0;
        step();
        chk("rst_mid_act",  freezeActive,   0);
        chk("rst_mid_left", freezeTimeLeft, 0);
        step();
        resetN = 1'b1;
        step();

        // Enable low clears and ignores a same-cycle collect
        collect(2'd2);
        chk("shd_on", shieldActive, 1);
        effectsEnable = 1'b0;
        collect(2'd2);
        chk("dis_shd_off", shieldActive, 0);
        effectsEnable = 1'b1;
        step();
        chk("dis_shd_ignored", shieldActive, 0);
        effectsEnable = 1'b0;
        collect(2'd0);
        chk("dis_life_supp", lifeUp, 0);
        effectsEnable = 1'b1;
        step();

        // Shield ending sequence
        collect(2'd2);
        for (int i = 0; i < 6; i++) sec();
        chk("shd_at4", shieldActive, 1);
`ifdef PRESENT_EFFECTS_WARN_EN
        chk("shd_warn_at4", shieldWarn, 0);
`endif
        sec();
`ifdef PRESENT_EFFECTS_WARN_EN
        chk("shd_warn_at3", shieldWarn, 1);
`endif
        sec();
`ifdef PRESENT_EFFECTS_WARN_EN
        chk("shd_warn_at2", shieldWarn, 0);
`endif
        sec();
        chk("shd_at1_act", shieldActive, 1);
`ifdef PRESENT_EFFECTS_WARN_EN
        chk("shd_warn_at1", shieldWarn, 1);
`endif
        sec();
        chk("shd_at0_act", shieldActive, 0);
`ifdef PRESENT_EFFECTS_WARN_EN
        chk("shd_warn_at0", shieldWarn, 0);
`endif

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
